output_port_arbiter: RTL and testbench

- Per-output-port allocator for the 5-port mesh router.
- Collects the port requests produced by the five input-side route computation units (N, E, W, S, L) for one output direction.
- Grants the output to one input per packet using round-robin, and holds the grant from HEADER to TAIL (wormhole lock).
- Gates every flit transfer with a credit counter that tracks free slots in the downstream input buffer.

---
 rtl/output_port_arbiter_pkg.sv | 21 ++
 rtl/output_port_arbiter_rr_picker5.sv | 26 ++
 rtl/output_port_arbiter.sv | 118 +++++++++++
 tb/tb_output_port_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_port_arbiter_pkg.sv
// Shared definitions for the mesh-router output port arbiter: flit codes, port indices, FSM state.
package output_port_arbiter_pkg;

    localparam int NPORTS = 5;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_E = 3'd1;
    localparam logic [2:0] PORT_W = 3'd2;
    localparam logic [2:0] PORT_S = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;

    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

endpackage

// File: rtl/output_port_arbiter_rr_picker5.sv
// Five-way round-robin picker: first eligible index after ptr, wrapping modulo five.
module rr_picker5
    import output_port_arbiter_pkg::*;
(
    input  logic [NPORTS-1:0] eligible,
    input  logic [2:0]        ptr,
    output logic              found,
    output logic [2:0]        idx
);

    int w_cand;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = 0;
        for (int k = 1; k <= NPORTS; k++) begin
            w_cand = (int'(ptr) + k) % NPORTS;
            if (!found && eligible[w_cand]) begin
                found = 1'b1;
                idx   = 3'(w_cand);
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Output port allocator: round-robin HEADER arbitration, wormhole lock until TAIL,
// and credit-gated flit transfer toward the downstream input buffer.
module output_port_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORTS-1:0]     req,
    input  logic [NPORTS-1:0]     empty,
    input  logic [3*NPORTS-1:0]   flit_id_in,
    input  logic                  credit_in,
    output logic [NPORTS-1:0]     grant,
    output logic [2:0]            xbar_sel,
    output logic                  valid_out,
    output logic                  busy,
    output logic [CNT_W-1:0]      credit_cnt,
    output logic                  err_credit
);

    arb_state_e         r_state;
    logic [2:0]         r_owner;
    logic [2:0]         r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic [NPORTS-1:0]  w_eligible;
    logic [2:0]         w_owner_flit;
    logic               w_owner_empty;
    logic               w_has_credit;
    logic               w_found;
    logic [2:0]         w_idx;
    logic               w_send;

    always_comb begin
        w_eligible    = '0;
        w_owner_flit  = '0;
        w_owner_empty = 1'b1;
        for (int i = 0; i < NPORTS; i++) begin
            w_eligible[i] = req[i] & ~empty[i] & (flit_id_in[3*i +: 3] == HEADER);
            if (r_owner == 3'(i)) begin
                w_owner_flit  = flit_id_in[3*i +: 3];
                w_owner_empty = empty[i];
            end
        end
    end

    rr_picker5 u_picker (
        .eligible (w_eligible),
        .ptr      (r_ptr),
        .found    (w_found),
        .idx      (w_idx)
    );

    assign w_has_credit = (r_cnt != '0);

    // The owner's req is deliberately not used here: the lock holds until TAIL.
    always_comb begin
        grant = '0;
        if (r_state == LOCKED && !w_owner_empty && w_has_credit) begin
            grant[r_owner] = 1'b1;
        end
    end

    assign w_send     = |grant;
    assign valid_out  = w_send;
    assign busy       = (r_state == LOCKED);
    assign xbar_sel   = r_owner;
    assign credit_cnt = r_cnt;
    assign err_credit = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= PORT_N;
            r_ptr   <= PORT_L;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found && w_has_credit) begin
                        r_owner <= w_idx;
                        r_state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_send && w_owner_flit == TAIL) begin
                        r_state <= IDLE;
                        r_ptr   <= r_owner;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A credit with no room left is a downstream protocol error: saturate and flag it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= CNT_W'(BUF_DEPTH);
            r_err <= 1'b0;
        end else begin
            case ({w_send, credit_in})
                2'b10: r_cnt <= r_cnt - CNT_W'(1);
                2'b01: begin
                    if (r_cnt == CNT_W'(BUF_DEPTH)) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: per-input flit queues feed the DUT, a packet-level model
// predicts grant/busy/valid/xbar_sel/credit_cnt/err_credit every cycle.
module tb_output_port_arbiter;
    import output_port_arbiter_pkg::*;

    localparam int BUF = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req;
    logic [4:0]  empty;
    logic [14:0] flit_id_in;
    logic        credit_in;
    logic [4:0]  grant;
    logic [2:0]  xbar_sel;
    logic        valid_out;
    logic        busy;
    logic [2:0]  credit_cnt;
    logic        err_credit;

    wire [13:0] dut_vec = {grant, busy, valid_out, xbar_sel, credit_cnt, err_credit};

    output_port_arbiter #(.BUF_DEPTH(BUF)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .empty      (empty),
        .flit_id_in (flit_id_in),
        .credit_in  (credit_in),
        .grant      (grant),
        .xbar_sel   (xbar_sel),
        .valid_out  (valid_out),
        .busy       (busy),
        .credit_cnt (credit_cnt),
        .err_credit (err_credit)
    );

    always #5 clk = ~clk;

    // Stimulus sources: one flit queue per input, plus bubble (forced empty) and req-drop knobs.
    logic [2:0] flit_q [5][$];
    bit         bubble [5];
    bit         drop   [5];
    bit         crd;

    // Packet-level model state.
    bit m_locked;
    bit m_err;
    int m_owner;
    int m_ptr;
    int m_cnt;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [4:0] m_grant();
        logic [4:0] g;
        g = '0;
        if (m_locked && flit_q[m_owner].size() != 0 && !bubble[m_owner] && m_cnt > 0)
            g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic bit m_elig(int c);
        return flit_q[c].size() != 0 && !bubble[c] && !drop[c] && flit_q[c][0] == HEADER;
    endfunction

    function automatic logic [13:0] m_vec();
        logic [4:0] g;
        g = m_grant();
        return {g, m_locked, |g, 3'(m_owner), 3'(m_cnt), m_err};
    endfunction

    task automatic flush();
        for (int i = 0; i < 5; i++) begin
            flit_q[i].delete();
            bubble[i] = 1'b0;
            drop[i]   = 1'b0;
        end
        crd = 1'b0;
    endtask

    task automatic push_pkt(int p, int len);
        flit_q[p].push_back(HEADER);
        for (int i = 0; i < len - 2; i++) flit_q[p].push_back(PAYLOAD);
        flit_q[p].push_back(TAIL);
    endtask

    task automatic drive();
        for (int i = 0; i < 5; i++) begin
            empty[i]             = (flit_q[i].size() == 0) || bubble[i];
            flit_id_in[3*i +: 3] = (flit_q[i].size() != 0) ? flit_q[i][0] : 3'b000;
            req[i]               = (flit_q[i].size() != 0) && !drop[i];
        end
        credit_in = crd;
    endtask

    // Advance the model across one clock edge, consume granted flits, land at posedge+1.
    task automatic advance();
        logic [4:0] g;
        g = m_grant();
        if (rst) begin
            m_locked = 1'b0;
            m_owner  = 0;
            m_ptr    = 4;
            m_cnt    = BUF;
            m_err    = 1'b0;
        end else begin
            if (m_locked) begin
                if (g != '0) begin
                    if (flit_q[m_owner][0] == TAIL) begin
                        m_locked = 1'b0;
                        m_ptr    = m_owner;
                    end
                    void'(flit_q[m_owner].pop_front());
                end
            end else if (m_cnt > 0) begin
                for (int k = 1; k <= 5; k++) begin
                    if (!m_locked && m_elig((m_ptr + k) % 5)) begin
                        m_locked = 1'b1;
                        m_owner  = (m_ptr + k) % 5;
                    end
                end
            end
            m_cnt = m_cnt - ((g != '0) ? 1 : 0) + (crd ? 1 : 0);
            if (m_cnt > BUF) begin
                m_cnt = BUF;
                m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush();
        drive();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive();
        @(negedge clk);
        n_checks++;
        if (dut_vec !== {5'b0, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_state got %b want %b", dut_vec, {5'b0, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0});
        end
        advance();
    endtask

    task automatic test_single_packet();
        int n_grant;
        n_grant = 0;
        do_reset();
        push_pkt(0, 3);
        for (int c = 0; c < 6; c++) begin
            drive();
            @(negedge clk);
            n_checks++;
            if (dut_vec !== m_vec()) begin
                n_errors++;
                $display("FAIL single cyc %0d got %b want %b", c, dut_vec, m_vec());
            end
            if (grant == 5'b00001) n_grant++;
            advance();
        end
        n_checks++;
        if (n_grant !== 3 || credit_cnt !== 3'd1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL single_end grants %0d cnt %0d busy %b want 3 1 0", n_grant, credit_cnt, busy);
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            bit seen;
            seen = 1'b0;
            push_pkt(1, 3);
            push_pkt(4, 3);
            crd = 1'b1;
            for (int c = 0; c < 10; c++) begin
                crd = (m_cnt < BUF) || (m_grant() != '0);
                drive();
                @(negedge clk);
                n_checks++;
                if (dut_vec !== m_vec()) begin
                    n_errors++;
                    $display("FAIL contention r%0d cyc %0d got %b want %b", r, c, dut_vec, m_vec());
                end
                if (!seen && grant != '0) begin
                    seen = 1'b1;
                    n_checks++;
                    if (grant !== 5'b00010) begin
                        n_errors++;
                        $display("FAIL contention_first r%0d got %b want 00010", r, grant);
                    end
                end
                advance();
            end
            crd = 1'b0;
        end
    endtask

    task automatic test_credit_stall();
        int sends;
        sends = 0;
        do_reset();
        push_pkt(0, 6);
        for (int c = 0; c < 13; c++) begin
            crd = (c == 8);
            drive();
            @(negedge clk);
            n_checks++;
            if (dut_vec !== m_vec()) begin
                n_errors++;
                $display("FAIL stall cyc %0d got %b want %b", c, dut_vec, m_vec());
            end
            if (valid_out) sends++;
            if (c == 7) begin
                n_checks++;
                if (sends !== 4 || grant !== 5'b0 || busy !== 1'b1 || credit_cnt !== 3'd0) begin
                    n_errors++;
                    $display("FAIL stall_hold sends %0d grant %b busy %b cnt %0d want 4 0 1 0",
                             sends, grant, busy, credit_cnt);
                end
            end
            advance();
        end
        n_checks++;
        if (sends !== 5 || credit_cnt !== 3'd0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_resume sends %0d cnt %0d busy %b want 5 0 1", sends, credit_cnt, busy);
        end
    endtask

    task automatic test_send_and_credit();
        do_reset();
        push_pkt(0, 2);
        for (int c = 0; c < 4; c++) begin
            drive();
            @(negedge clk);
            advance();
        end
        push_pkt(0, 6);
        for (int c = 0; c < 9; c++) begin
            crd = (m_grant() != '0);
            drive();
            @(negedge clk);
            n_checks++;
            if (dut_vec !== m_vec() || credit_cnt !== 3'd2) begin
                n_errors++;
                $display("FAIL send_credit cyc %0d got %b want %b (cnt must stay 2)", c, dut_vec, m_vec());
            end
            advance();
        end
        crd = 1'b0;
    endtask

    task automatic test_owner_empty();
        do_reset();
        push_pkt(2, 4);
        push_pkt(3, 3);
        for (int c = 0; c < 12; c++) begin
            bubble[2] = (c >= 3 && c <= 5);
            drive();
            @(negedge clk);
            n_checks++;
            if (dut_vec !== m_vec()) begin
                n_errors++;
                $display("FAIL owner_empty cyc %0d got %b want %b", c, dut_vec, m_vec());
            end
            if (bubble[2] || c == 6) begin
                n_checks++;
                if (grant !== (c == 6 ? 5'b00100 : 5'b00000) || busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL owner_empty_gate cyc %0d grant %b busy %b", c, grant, busy);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        push_pkt(0, 5);
        for (int c = 0; c < 3; c++) begin
            drive();
            @(negedge clk);
            advance();
        end
        do_reset();
        crd = 1'b1;
        drive();
        @(negedge clk);
        n_checks++;
        if (grant !== 5'b0 || busy !== 1'b0 || credit_cnt !== 3'd4 || err_credit !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset grant %b busy %b cnt %0d err %b want 0 0 4 0",
                     grant, busy, credit_cnt, err_credit);
        end
        advance();
        crd = 1'b0;
        drive();
        @(negedge clk);
        n_checks++;
        if (err_credit !== 1'b1 || credit_cnt !== 3'd4 || dut_vec !== m_vec()) begin
            n_errors++;
            $display("FAIL err_credit got err %b cnt %0d want 1 4", err_credit, credit_cnt);
        end
        advance();
        push_pkt(1, 2);
        push_pkt(0, 2);
        for (int c = 0; c < 6; c++) begin
            drive();
            @(negedge clk);
            n_checks++;
            if (dut_vec !== m_vec() || (c == 1 && grant !== 5'b00001)) begin
                n_errors++;
                $display("FAIL midreset_ptr cyc %0d got %b want %b", c, dut_vec, m_vec());
            end
            advance();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 5; i++) begin
                if (flit_q[i].size() == 0 && $urandom_range(3) == 0)
                    push_pkt(i, int'($urandom_range(2, 6)));
                bubble[i] = ($urandom_range(9) == 0);
                drop[i]   = ($urandom_range(7) == 0);
            end
            crd = ((m_cnt < BUF) || (m_grant() != '0)) && ($urandom_range(2) != 0);
            drive();
            @(negedge clk);
            n_checks++;
            if (dut_vec !== m_vec()) begin
                n_errors++;
                $display("FAIL random cyc %0d got %b want %b", c, dut_vec, m_vec());
            end
            advance();
        end
        crd = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush();
        drive();
        @(posedge clk);
        #1;
        test_reset();
        test_single_packet();
        test_contention();
        test_credit_stall();
        test_send_and_credit();
        test_owner_empty();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
